power_request_fsm: RTL and testbench

Initiator side of the power sequencer handshake. Turns host commands and fault inputs into the `power_up`/`power_down` requests the sequencer consumes, and tracks the sequencer's `power_up_done`/`power_down_done` replies. Adds request timeouts, timed power-cycle, optional auto power-on after reset, and a latched crash/fault lockout. Sits between the monitor's register/bus logic and the sequencer.

---
 rtl/power_request_fsm.sv | 168 ++++++++++++++++
 tb/tb_power_request_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_request_fsm.sv
// Initiator side of the power sequencer handshake: turns host commands and
// crash inputs into power_up/power_down requests with timeouts and power-cycle.
module power_request_fsm #(
  parameter logic [31:0] TIMEOUT        = 32'd200000,
  parameter logic [31:0] CYCLE_OFF_TIME = 32'd1000000,
  parameter logic        AUTO_POWER_UP  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_power_up,
  input  logic       cmd_power_down,
  input  logic       cmd_power_cycle,
  input  logic       crash,
  input  logic       fault_clear,
  input  logic       power_up_done,
  input  logic       power_down_done,
  output logic       power_up,
  output logic       power_down,
  output logic [2:0] state_o,
  output logic       fault_latched,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_REQ_UP     = 3'd1,
    S_ON         = 3'd2,
    S_REQ_DOWN   = 3'd3,
    S_CYCLE_WAIT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        cycle_pending_q, cycle_pending_d;
  logic        boot_pending_q, boot_pending_d;
  logic        fault_latched_q, fault_latched_d;
  logic        timeout_err_q, timeout_err_d;
  logic        timeout_hit;
  logic        stop_req;

  assign stop_req = crash | cmd_power_down;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_OFF;
      timer_q         <= 32'd0;
      cycle_pending_q <= 1'b0;
      boot_pending_q  <= AUTO_POWER_UP;
      fault_latched_q <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      cycle_pending_q <= cycle_pending_d;
      boot_pending_q  <= boot_pending_d;
      fault_latched_q <= fault_latched_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    cycle_pending_d = cycle_pending_q;
    boot_pending_d  = boot_pending_q;
    timeout_hit     = 1'b0;

    case (state_q)
      S_OFF: begin
        // A cycle command from OFF is just a power-on.
        if (!stop_req && !fault_latched_q &&
            (cmd_power_cycle || cmd_power_up || boot_pending_q)) begin
          state_d        = S_REQ_UP;
          timer_d        = TIMEOUT;
          boot_pending_d = 1'b0;
        end
      end

      S_REQ_UP: begin
        if (stop_req) begin
          state_d = S_REQ_DOWN;
          timer_d = TIMEOUT;
        end else if (power_up_done) begin
          state_d = S_ON;
        end else if (timer_q == 32'd0) begin
          timeout_hit = 1'b1;
          state_d     = S_REQ_DOWN;
          timer_d     = TIMEOUT;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      S_ON: begin
        if (stop_req) begin
          state_d = S_REQ_DOWN;
          timer_d = TIMEOUT;
        end else if (cmd_power_cycle) begin
          state_d         = S_REQ_DOWN;
          timer_d         = TIMEOUT;
          cycle_pending_d = 1'b1;
        end
      end

      S_REQ_DOWN: begin
        if (power_down_done) begin
          if (cycle_pending_q && !fault_latched_q) begin
            state_d = S_CYCLE_WAIT;
            timer_d = CYCLE_OFF_TIME;
          end else begin
            state_d         = S_OFF;
            cycle_pending_d = 1'b0;
          end
        end else if (timer_q == 32'd0) begin
          // Keep requesting power-down indefinitely; the error stays asserted.
          timeout_hit = 1'b1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      S_CYCLE_WAIT: begin
        if (stop_req) begin
          state_d         = S_OFF;
          cycle_pending_d = 1'b0;
        end else if (timer_q == 32'd0) begin
          state_d         = S_REQ_UP;
          timer_d         = TIMEOUT;
          cycle_pending_d = 1'b0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      default: begin
        state_d = S_REQ_DOWN;
        timer_d = TIMEOUT;
      end
    endcase

    if (crash) begin
      boot_pending_d = 1'b0;
    end

    if (crash) begin
      fault_latched_d = 1'b1;
    end else if (fault_clear) begin
      fault_latched_d = 1'b0;
    end else begin
      fault_latched_d = fault_latched_q;
    end

    if (timeout_hit) begin
      timeout_err_d = 1'b1;
    end else if (fault_clear) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  assign power_up      = (state_q == S_REQ_UP);
  assign power_down    = (state_q == S_REQ_DOWN);
  assign state_o       = state_q;
  assign fault_latched = fault_latched_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_power_request_fsm.sv
// Bench for power_request_fsm: directed scenarios plus random traffic on two
// instances (auto power-up off and on), checked against a deadline-based model.
module tb_power_request_fsm;

  localparam int TO  = 20;
  localparam int COT = 5;

  localparam int P_OFF = 0, P_REQ_UP = 1, P_ON = 2, P_REQ_DOWN = 3, P_CYCLE_WAIT = 4;

  typedef struct packed {
    logic crash;
    logic fault_clear;
    logic up;
    logic down;
    logic cycle;
    logic pud;
    logic pdd;
  } in_t;

  typedef struct packed {
    int phase;
    int deadline;   // edge index at which the running timer expires
    bit cyc;
    bit boot;
    bit fault;
    bit terr;
  } model_t;

  logic clk = 1'b0;
  logic rst_n0, rst_n1;
  in_t  in0, in1;
  logic pu0, pd0, fl0, te0, pu1, pd1, fl1, te1;
  logic [2:0] st0, st1;

  model_t m0, m1;
  int edge_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  power_request_fsm #(.TIMEOUT(32'd20), .CYCLE_OFF_TIME(32'd5), .AUTO_POWER_UP(1'b0)) dut0 (
    .clk(clk), .reset_n(rst_n0),
    .cmd_power_up(in0.up), .cmd_power_down(in0.down), .cmd_power_cycle(in0.cycle),
    .crash(in0.crash), .fault_clear(in0.fault_clear),
    .power_up_done(in0.pud), .power_down_done(in0.pdd),
    .power_up(pu0), .power_down(pd0), .state_o(st0),
    .fault_latched(fl0), .timeout_err(te0)
  );

  power_request_fsm #(.TIMEOUT(32'd20), .CYCLE_OFF_TIME(32'd5), .AUTO_POWER_UP(1'b1)) dut1 (
    .clk(clk), .reset_n(rst_n1),
    .cmd_power_up(in1.up), .cmd_power_down(in1.down), .cmd_power_cycle(in1.cycle),
    .crash(in1.crash), .fault_clear(in1.fault_clear),
    .power_up_done(in1.pud), .power_down_done(in1.pdd),
    .power_up(pu1), .power_down(pd1), .state_o(st1),
    .fault_latched(fl1), .timeout_err(te1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  function automatic model_t model_reset(input bit auto_up);
    model_t r;
    r = '0;
    r.phase = P_OFF;
    r.boot  = auto_up;
    return r;
  endfunction

  // Applies the operating rules to one sampled edge n.
  function automatic model_t model_step(input model_t m, input in_t i, input int n);
    model_t r;
    bit stop, expired, to_evt;
    r       = m;
    stop    = i.crash || i.down;
    expired = (n >= m.deadline);
    to_evt  = 1'b0;
    case (m.phase)
      P_OFF:
        if (!stop && !m.fault && (i.cycle || i.up || m.boot)) begin
          r.phase = P_REQ_UP; r.deadline = n + TO + 1; r.boot = 1'b0;
        end
      P_REQ_UP:
        if (stop) begin
          r.phase = P_REQ_DOWN; r.deadline = n + TO + 1;
        end else if (i.pud) begin
          r.phase = P_ON;
        end else if (expired) begin
          to_evt = 1'b1; r.phase = P_REQ_DOWN; r.deadline = n + TO + 1;
        end
      P_ON:
        if (stop || i.cycle) begin
          r.phase = P_REQ_DOWN; r.deadline = n + TO + 1;
          if (!stop) r.cyc = 1'b1;
        end
      P_REQ_DOWN:
        if (i.pdd) begin
          if (m.cyc && !m.fault) begin
            r.phase = P_CYCLE_WAIT; r.deadline = n + COT + 1;
          end else begin
            r.phase = P_OFF; r.cyc = 1'b0;
          end
        end else if (expired) begin
          to_evt = 1'b1;
        end
      default:
        if (stop) begin
          r.phase = P_OFF; r.cyc = 1'b0;
        end else if (expired) begin
          r.phase = P_REQ_UP; r.deadline = n + TO + 1; r.cyc = 1'b0;
        end
    endcase
    if (i.crash) r.boot = 1'b0;
    r.fault = i.crash ? 1'b1 : (i.fault_clear ? 1'b0 : m.fault);
    r.terr  = to_evt ? 1'b1 : (i.fault_clear ? 1'b0 : m.terr);
    return r;
  endfunction

  function automatic logic [6:0] exp_vec(input model_t m);
    logic [2:0] ph;
    ph = m.phase[2:0];
    return {ph, m.phase == P_REQ_UP, m.phase == P_REQ_DOWN, m.fault, m.terr};
  endfunction

  task automatic compare_all();
    check_val("dut0_outputs", {25'd0, st0, pu0, pd0, fl0, te0}, {25'd0, exp_vec(m0)});
    check_val("dut1_outputs", {25'd0, st1, pu1, pd1, fl1, te1}, {25'd0, exp_vec(m1)});
  endtask

  task automatic tick();
    model_t n0, n1;
    n0 = rst_n0 ? model_step(m0, in0, edge_n + 1) : model_reset(1'b0);
    n1 = rst_n1 ? model_step(m1, in1, edge_n + 1) : model_reset(1'b1);
    @(posedge clk);
    #1;
    edge_n++;
    m0 = n0;
    m1 = n1;
    compare_all();
  endtask

  // One-cycle pulse on input set 0: set, tick, clear.
  task automatic pulse0(input in_t v);
    in0 = v;
    tick();
    in0 = '0;
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.crash       = ($urandom_range(0, 99) < 2);
    v.fault_clear = ($urandom_range(0, 99) < 6);
    v.up          = ($urandom_range(0, 99) < 6);
    v.down        = ($urandom_range(0, 99) < 4);
    v.cycle       = ($urandom_range(0, 99) < 5);
    v.pud         = ($urandom_range(0, 99) < 12);
    v.pdd         = ($urandom_range(0, 99) < 12);
    return v;
  endfunction

  in_t v;

  initial begin
    in0 = '0; in1 = '0;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    edge_n = 0;
    m0 = model_reset(1'b0);
    m1 = model_reset(1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    check_val("reset_state0", {29'd0, st0}, 32'd0);
    check_val("reset_pu1", {31'd0, pu1}, 32'd0);
    compare_all();

    $display("scenario: auto power-up after reset");
    tick();
    check_val("boot_power_up", {31'd0, pu1}, 32'd1);
    tick(); tick();
    rst_n1 = 1'b0;
    #1;
    m1 = model_reset(1'b1);
    check_val("async_rst_pu", {31'd0, pu1}, 32'd0);
    check_val("async_rst_state", {29'd0, st1}, 32'd0);
    compare_all();
    tick();
    rst_n1 = 1'b1;
    tick();
    check_val("reboot_power_up", {31'd0, pu1}, 32'd1);
    in1.pud = 1'b1; tick(); in1.pud = 1'b0;

    $display("scenario: power up with done after 10 cycles");
    v = '0; v.up = 1'b1; pulse0(v);
    check_val("tp1_pu_first", {31'd0, pu0}, 32'd1);
    check_val("tp1_pd", {31'd0, pd0}, 32'd0);
    repeat (9) tick();
    check_val("tp1_pu_last", {31'd0, pu0}, 32'd1);
    v = '0; v.pud = 1'b1; pulse0(v);
    check_val("tp1_on", {29'd0, st0}, 32'd2);

    $display("scenario: power-up timeout");
    v = '0; v.down = 1'b1; pulse0(v);
    check_val("tp2_req_down", {29'd0, st0}, 32'd3);
    v = '0; v.pdd = 1'b1; pulse0(v);
    check_val("tp2_off", {29'd0, st0}, 32'd0);
    v = '0; v.up = 1'b1; pulse0(v);
    repeat (20) tick();
    check_val("tp2_still_up", {29'd0, st0}, 32'd1);
    check_val("tp2_no_err_yet", {31'd0, te0}, 32'd0);
    tick();
    check_val("tp2_to_state", {29'd0, st0}, 32'd3);
    check_val("tp2_to_err", {31'd0, te0}, 32'd1);
    v = '0; v.pdd = 1'b1; pulse0(v);
    check_val("tp2_back_off", {29'd0, st0}, 32'd0);
    v = '0; v.fault_clear = 1'b1; pulse0(v);
    check_val("tp2_err_clear", {31'd0, te0}, 32'd0);

    $display("scenario: power cycle");
    v = '0; v.up = 1'b1; pulse0(v);
    v = '0; v.pud = 1'b1; pulse0(v);
    v = '0; v.cycle = 1'b1; pulse0(v);
    check_val("tp3_req_down", {29'd0, st0}, 32'd3);
    tick(); tick();
    v = '0; v.pdd = 1'b1; pulse0(v);
    check_val("tp3_wait", {29'd0, st0}, 32'd4);
    repeat (5) tick();
    check_val("tp3_wait_end", {29'd0, st0}, 32'd4);
    tick();
    check_val("tp3_req_up", {29'd0, st0}, 32'd1);
    check_val("tp3_pu", {31'd0, pu0}, 32'd1);
    v = '0; v.pud = 1'b1; pulse0(v);
    v = '0; v.down = 1'b1; pulse0(v);
    v = '0; v.pdd = 1'b1; pulse0(v);
    check_val("tp3_pending_cleared", {29'd0, st0}, 32'd0);

    $display("scenario: crash lockout");
    v = '0; v.up = 1'b1; pulse0(v);
    v = '0; v.crash = 1'b1; pulse0(v);
    check_val("tp4_req_down", {29'd0, st0}, 32'd3);
    check_val("tp4_fault", {31'd0, fl0}, 32'd1);
    v = '0; v.pdd = 1'b1; pulse0(v);
    v = '0; v.up = 1'b1; pulse0(v);
    check_val("tp4_up_blocked", {29'd0, st0}, 32'd0);
    v = '0; v.crash = 1'b1; v.fault_clear = 1'b1; pulse0(v);
    check_val("tp4_clear_tie", {31'd0, fl0}, 32'd1);
    v = '0; v.fault_clear = 1'b1; pulse0(v);
    check_val("tp4_cleared", {31'd0, fl0}, 32'd0);
    v = '0; v.up = 1'b1; pulse0(v);
    check_val("tp4_up_ok", {29'd0, st0}, 32'd1);
    v = '0; v.pud = 1'b1; pulse0(v);

    $display("scenario: crash with cycle in ON");
    v = '0; v.crash = 1'b1; v.cycle = 1'b1; pulse0(v);
    check_val("tp6_req_down", {29'd0, st0}, 32'd3);
    v = '0; v.pdd = 1'b1; pulse0(v);
    check_val("tp6_off", {29'd0, st0}, 32'd0);
    v = '0; v.fault_clear = 1'b1; pulse0(v);

    $display("scenario: random traffic");
    for (int k = 0; k < 4000; k++) begin
      in0 = rand_in();
      in1 = rand_in();
      if ($urandom_range(0, 499) == 0) begin
        $display("random reset of dut0 at edge %0d", edge_n);
        rst_n0 = 1'b0;
        #1;
        m0 = model_reset(1'b0);
        compare_all();
        tick();
        rst_n0 = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        $display("random reset of dut1 at edge %0d", edge_n);
        rst_n1 = 1'b0;
        #1;
        m1 = model_reset(1'b1);
        compare_all();
        tick();
        rst_n1 = 1'b1;
      end else begin
        tick();
      end
    end
    in0 = '0; in1 = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
